// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared constants and types for the unified-memory port arbiter.
//   - RV32 load/store funct3 encodings (the memory decodes size/sign from them)
//   - NOP_INSTR: addi x0,x0,0, delivered after reset and on a misaligned fetch
//   - grant_e: which requester owns the memory port in the current cycle
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_DATA  = 2'd2
  } grant_e;

endpackage

// File: rtl/mem_align_checker.sv
// ---------------------------------------------------------------------------
// mem_align_checker
//   Flags a misaligned access for the request that currently owns the port.
//   Ports:
//     funct3     in  3  load/store size (ignored for fetches)
//     addr       in  2  low byte-address bits of the granted access
//     is_fetch   in  1  granted access is an instruction fetch (always a word)
//     misaligned out 1  access must be suppressed
//   Byte accesses can never be misaligned; unknown funct3 codes are treated
//   as byte-sized so they pass through unchanged.
// ---------------------------------------------------------------------------
module mem_align_checker
  import mem_arb_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr,
  input  logic       is_fetch,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    if (is_fetch) begin
      misaligned = (addr != 2'b00);
    end else begin
      case (funct3)
        F3_LW:         misaligned = (addr != 2'b00);
        F3_LH, F3_LHU: misaligned = addr[0];
        default:       misaligned = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Initiator side of the single-port unified instruction/data memory.
//   Each cycle the port goes to the MEM stage (loads/stores) or the IF stage
//   (fetch). Data has priority, but after MAX_DATA_RUN consecutive data
//   cycles one cycle is handed to the fetch side so IF cannot starve.
//   Reads are combinational (zero latency); stores commit on the clock edge
//   that ends the data cycle.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     if_req, if_pc                 fetch request and byte address
//     if_instr, if_valid, if_stall  fetched/held instruction, fresh flag, stall
//     mem_rd, mem_wr, mem_funct3,
//     mem_addr, mem_wdata           load/store request from MEM stage
//     mem_rdata, mem_done,
//     mem_stall                     load data, completion, stall to MEM stage
//     m_MemRead, m_MemWrite,
//     m_function3, m_addr,
//     m_data_in, m_data_out         memory-side port (word-indexed address)
//     misalign_err                  sticky misaligned-access flag
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int          ADDR_W       = 6,
  parameter int          MAX_DATA_RUN = 3,
  parameter logic [31:0] NOP_INSTR    = mem_arb_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_stall,
  output logic              m_MemRead,
  output logic              m_MemWrite,
  output logic [2:0]        m_function3,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_data_in,
  input  logic [31:0]       m_data_out,
  output logic              misalign_err
);

  import mem_arb_pkg::grant_e;
  import mem_arb_pkg::GNT_IDLE;
  import mem_arb_pkg::GNT_FETCH;
  import mem_arb_pkg::GNT_DATA;
  import mem_arb_pkg::F3_LW;

  localparam int              RUN_W   = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  logic [RUN_W-1:0] data_run_q, data_run_d;
  logic [31:0]      last_instr_q, last_instr_d;
  logic             misalign_err_q, misalign_err_d;

  logic   dreq;
  grant_e grant;
  logic   chk_misaligned;
  logic   unused_addr_bits;

  // Upper address bits are deliberately dropped: addresses wrap in memory.
  assign unused_addr_bits = ^{if_pc[31:ADDR_W+2], mem_addr[31:ADDR_W+2]};

  assign dreq = mem_rd | mem_wr;

  // Grant decision. Reset parks the port so nothing can be written.
  always_comb begin
    grant = GNT_IDLE;
    if (!rst) begin
      if (dreq && (data_run_q < RUN_MAX)) begin
        grant = GNT_DATA;
      end else if (if_req) begin
        grant = GNT_FETCH;
      end
    end
  end

  mem_align_checker u_align (
    .funct3     (mem_funct3),
    .addr       ((grant == GNT_FETCH) ? if_pc[1:0] : mem_addr[1:0]),
    .is_fetch   (grant == GNT_FETCH),
    .misaligned (chk_misaligned)
  );

  always_comb begin
    m_MemRead      = 1'b0;
    m_MemWrite     = 1'b0;
    m_function3    = 3'b000;
    m_addr         = '0;
    m_data_in      = '0;
    mem_rdata      = '0;
    mem_done       = 1'b0;
    if_valid       = 1'b0;
    if_instr       = last_instr_q;
    // A pending requester that did not get the port is stalled.
    if_stall       = if_req & ~rst;
    mem_stall      = dreq & ~rst;
    data_run_d     = '0;
    last_instr_d   = last_instr_q;
    misalign_err_d = misalign_err_q;

    case (grant)
      GNT_DATA: begin
        m_addr      = mem_addr[ADDR_W+1:2];
        m_function3 = mem_funct3;
        m_data_in   = mem_wr ? mem_wdata : 32'h0;
        mem_done    = 1'b1;
        mem_stall   = 1'b0;
        data_run_d  = data_run_q + 1'b1;
        // Simultaneous load and store: the store proceeds, but it is an error.
        if (mem_rd && mem_wr) begin
          misalign_err_d = 1'b1;
        end
        if (chk_misaligned) begin
          // Suppressed access still completes so the MEM stage does not hang.
          misalign_err_d = 1'b1;
        end else begin
          m_MemWrite = mem_wr;
          m_MemRead  = mem_rd & ~mem_wr;
          mem_rdata  = m_data_out;
        end
      end
      GNT_FETCH: begin
        m_addr      = if_pc[ADDR_W+1:2];
        m_function3 = F3_LW;
        if_valid    = 1'b1;
        if_stall    = 1'b0;
        if (chk_misaligned) begin
          if_instr       = NOP_INSTR;
          misalign_err_d = 1'b1;
        end else begin
          if_instr = m_data_out;
        end
        last_instr_d = if_instr;
      end
      default: begin
      end
    endcase

    if (rst) begin
      if_instr = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_run_q     <= '0;
      last_instr_q   <= NOP_INSTR;
      misalign_err_q <= 1'b0;
    end else begin
      data_run_q     <= data_run_d;
      last_instr_q   <= last_instr_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [2:0]  LW  = 3'b010;
  localparam logic [2:0]  LH  = 3'b001;
  localparam logic [2:0]  LBU = 3'b100;
  localparam logic [2:0]  SW  = 3'b010;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_stall;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic        m_MemRead;
  logic        m_MemWrite;
  logic [2:0]  m_function3;
  logic [5:0]  m_addr;
  logic [31:0] m_data_in;
  logic [31:0] m_data_out;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(6), .MAX_DATA_RUN(3), .NOP_INSTR(32'h0000_0013)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .if_stall     (if_stall),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_funct3   (mem_funct3),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .mem_stall    (mem_stall),
    .m_MemRead    (m_MemRead),
    .m_MemWrite   (m_MemWrite),
    .m_function3  (m_function3),
    .m_addr       (m_addr),
    .m_data_in    (m_data_in),
    .m_data_out   (m_data_out),
    .misalign_err (misalign_err)
  );

  // Memory model: combinational read, word write on the clock edge.
  assign m_data_out = mem[m_addr];
  always @(posedge clk) begin
    if (m_MemWrite) mem[m_addr] <= m_data_in;
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        iv;
    logic        is;
    logic [31:0] rdata;
    logic        md;
    logic        ms;
    logic        mr;
    logic        mw;
    logic [5:0]  ma;
    logic [2:0]  f3;
    logic [31:0] din;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  task automatic cmp(input string txn, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", txn, fld, act, req);
    end
  endtask

  task automatic expect_out(input string n, input logic [31:0] instr, input logic iv, input logic is,
                            input logic [31:0] rdata, input logic md, input logic ms, input logic mr,
                            input logic mw, input logic [5:0] ma, input logic [2:0] f3,
                            input logic [31:0] din, input logic err);
    exp_t e;
    e.name = n; e.instr = instr; e.iv = iv; e.is = is; e.rdata = rdata; e.md = md; e.ms = ms;
    e.mr = mr; e.mw = mw; e.ma = ma; e.f3 = f3; e.din = din; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic ir, input logic [31:0] pc, input logic rd,
                       input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    rst = r; if_req = ir; if_pc = pc; mem_rd = rd; mem_wr = wr;
    mem_funct3 = f3; mem_addr = a; mem_wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with a pending expectation, sample mid-cycle and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.name, "if_instr",     if_instr,     e.instr);
        cmp(e.name, "if_valid",     {31'd0, if_valid},   {31'd0, e.iv});
        cmp(e.name, "if_stall",     {31'd0, if_stall},   {31'd0, e.is});
        cmp(e.name, "mem_rdata",    mem_rdata,    e.rdata);
        cmp(e.name, "mem_done",     {31'd0, mem_done},   {31'd0, e.md});
        cmp(e.name, "mem_stall",    {31'd0, mem_stall},  {31'd0, e.ms});
        cmp(e.name, "m_MemRead",    {31'd0, m_MemRead},  {31'd0, e.mr});
        cmp(e.name, "m_MemWrite",   {31'd0, m_MemWrite}, {31'd0, e.mw});
        cmp(e.name, "m_addr",       {26'd0, m_addr},     {26'd0, e.ma});
        cmp(e.name, "m_function3",  {29'd0, m_function3}, {29'd0, e.f3});
        cmp(e.name, "m_data_in",    m_data_in,    e.din);
        cmp(e.name, "misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
        $display("txn %-12s instr=%h iv=%0d is=%0d rdata=%h done=%0d mstall=%0d rd=%0d wr=%0d addr=%0d err=%0d",
                 e.name, if_instr, if_valid, if_stall, mem_rdata, mem_done, mem_stall,
                 m_MemRead, m_MemWrite, m_addr, misalign_err);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h0000_2083;
    mem[1] = 32'h1111_2222;
    mem[3] = 32'h3333_4444;

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset held while a store is requested: nothing reaches memory.
    drive(1, 1, 0, 0, 1, SW, 32'h8, 32'hDEAD_BEEF);
    expect_out("rst_wr", NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    cmp("rst_wr", "mem2", mem[2], 32'hA000_0002);

    drive(0, 1, 0, 0, 0, 0, 0, 0);
    expect_out("fetch0", 32'h0000_2083, 1, 0, 0, 0, 0, 0, 0, 0, LW, 0, 0);
    tick();

    drive(0, 1, 32'h4, 1, 0, LW, 32'h4, 0);
    expect_out("load_w4", 32'h0000_2083, 0, 1, 32'h1111_2222, 1, 0, 1, 0, 1, LW, 0, 0);
    tick();

    drive(0, 1, 32'h4, 0, 0, 0, 0, 0);
    expect_out("fetch4", 32'h1111_2222, 1, 0, 0, 0, 0, 0, 0, 1, LW, 0, 0);
    tick();

    // Store burst with fetch pending: D,D,D,F,D.
    for (int k = 1; k <= 5; k++) begin
      wd = 32'hC0DE_0000 | 32'(k);
      drive(0, 1, 32'h8, 0, 1, SW, 32'hC, wd);
      case (k)
        1: expect_out("burst1", 32'h1111_2222, 0, 1, 32'h3333_4444, 1, 0, 0, 1, 3, SW, wd, 0);
        2: expect_out("burst2", 32'h1111_2222, 0, 1, 32'hC0DE_0001, 1, 0, 0, 1, 3, SW, wd, 0);
        3: expect_out("burst3", 32'h1111_2222, 0, 1, 32'hC0DE_0002, 1, 0, 0, 1, 3, SW, wd, 0);
        4: expect_out("burst4", 32'hA000_0002, 1, 0, 0, 0, 1, 0, 0, 2, LW, 0, 0);
        default: expect_out("burst5", 32'hA000_0002, 0, 1, 32'hC0DE_0003, 1, 0, 0, 1, 3, SW, wd, 0);
      endcase
      tick();
    end
    cmp("burst", "mem3", mem[3], 32'hC0DE_0005);

    drive(0, 0, 0, 0, 1, SW, 32'hE, 32'hBADB_AD00);
    expect_out("sw_misal", 32'hA000_0002, 0, 0, 0, 1, 0, 0, 0, 3, SW, 32'hBADB_AD00, 0);
    tick();
    cmp("sw_misal", "mem3", mem[3], 32'hC0DE_0005);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("idle_err", 32'hA000_0002, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();

    drive(0, 0, 0, 1, 0, LH, 32'h5, 0);
    expect_out("lh_misal", 32'hA000_0002, 0, 0, 0, 1, 0, 0, 0, 1, LH, 0, 1);
    tick();

    drive(0, 0, 0, 1, 0, LBU, 32'h7, 0);
    expect_out("lbu_ok", 32'hA000_0002, 0, 0, 32'h1111_2222, 1, 0, 1, 0, 1, LBU, 0, 1);
    tick();

    drive(0, 1, 32'h6, 0, 0, 0, 0, 0);
    expect_out("fetch_misal", NOP, 1, 0, 0, 0, 0, 0, 0, 1, LW, 0, 1);
    tick();

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("hold_nop", NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();

    drive(0, 0, 0, 0, 1, SW, 32'h8, 32'h5555_0001);
    expect_out("sw8", NOP, 0, 0, 32'hA000_0002, 1, 0, 0, 1, 2, SW, 32'h5555_0001, 1);
    tick();

    // Reset in the middle of a store run: write aborted, run counter cleared.
    drive(1, 1, 0, 0, 1, SW, 32'h8, 32'h6666_0002);
    expect_out("rst_mid", NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    cmp("rst_mid", "mem2", mem[2], 32'h5555_0001);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("post_rst", NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    drive(0, 1, 0, 1, 1, SW, 32'hC, 32'h1234_5678);
    expect_out("rdwr", NOP, 0, 1, 32'hC0DE_0005, 1, 0, 0, 1, 3, SW, 32'h1234_5678, 0);
    tick();

    drive(0, 1, 0, 0, 1, SW, 32'hC, 32'h9ABC_DEF0);
    expect_out("run2", NOP, 0, 1, 32'h1234_5678, 1, 0, 0, 1, 3, SW, 32'h9ABC_DEF0, 1);
    tick();

    drive(0, 1, 0, 0, 1, SW, 32'hC, 32'h0F0F_0F0F);
    expect_out("run3", NOP, 0, 1, 32'h9ABC_DEF0, 1, 0, 0, 1, 3, SW, 32'h0F0F_0F0F, 1);
    tick();

    drive(0, 1, 0, 0, 1, SW, 32'hC, 32'h1111_0000);
    expect_out("forced_f", 32'h0000_2083, 1, 0, 0, 0, 1, 0, 0, 0, LW, 0, 1);
    tick();
    cmp("forced_f", "mem3", mem[3], 32'h0F0F_0F0F);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
